debounce_bank: RTL
==================

// Module: debounce_bank
// PURPOSE
//  Multi-channel, parametrised debouncer for push-buttons, switches and clear/reset requests.
//  Each channel has a synchroniser chain and a stable-count filter.
//  The stable level updates only after STABLE_TICKS consecutive sample ticks at the new value.
//  Outputs: debounced levels plus one-clk rise/fall pulses per channel.
//  Sits between board pins and control FSMs; sampling is gated by a tick enable from the clock divider.
// PARAMETERS
//  N_CH          4   number of independent channels
//  SYNC_STAGES   2   synchroniser flops per channel (min 2)
//  STABLE_TICKS  3   consecutive mismatching ticks needed to flip output (min 1)
//  REPEAT_DELAY  50  ticks held before first repeat pulse (auto-repeat build only)
//  REPEAT_RATE   10  ticks between subsequent repeat pulses (auto-repeat build only)
// PORTS
//  clk         in   1     system clock; all logic on posedge
//  reset       in   1     synchronous, active-high reset
//  tick        in   1     sample enable; filter counters advance only when 1
//  raw_in      in   N_CH  asynchronous raw inputs
//  db_out      out  N_CH  debounced stable level
//  rise        out  N_CH  1-clk pulse when db_out goes 0->1
//  fall        out  N_CH  1-clk pulse when db_out goes 1->0
//  any_change  out  1     OR of all rise|fall bits, same cycle
//  repeat_p    out  N_CH  1-clk auto-repeat pulse; constant 0 if feature compiled out
// BEHAVIOUR
//  Reset values (after a reset edge): sync chains 0, db_out 0, counters 0, rise/fall/repeat_p/any_change 0.
//  Synchroniser: shifts on every clk, independent of tick. s_out is the last stage.
//  Filter, per channel, evaluated only on edges with tick=1:
//   - s_out != db_out: cnt <= cnt+1.
//   - When that increment would reach STABLE_TICKS: db_out <= s_out and cnt <= 0.
//   - s_out == db_out: cnt <= 0. A glitch shorter than STABLE_TICKS ticks is discarded; no pulse.
//  Filter on edges with tick=0: cnt and db_out hold.
//  Latency with tick=1 and raw changed before edge 0: db_out flips at edge SYNC_STAGES+STABLE_TICKS-1.
//   - Defaults: flips at edge 4.
//  Pulses:
//   - rise/fall are registered and high for exactly the one cycle following the db_out flip edge.
//   - rise/fall never overlap on the same channel.
//  Channels are fully independent. Simultaneous flips on several channels give simultaneous pulses.
//   - any_change is 1 in that cycle.
//  Counter width: $clog2(STABLE_TICKS+1). The counter never exceeds STABLE_TICKS-1 between ticks.
//  Reset mid-count: count is discarded. After release, a held input needs the full latency again.
//  Reset asserted while db_out=1: db_out drops to 0 with no fall pulse.
// CONFIGURATION
//  Macro DEBOUNCE_AUTOREPEAT_EN:
//  Defined:
//   - Per-channel repeat counter counts ticks while db_out=1.
//   - repeat_p pulses once after REPEAT_DELAY ticks, then every REPEAT_RATE ticks.
//   - Counter clears when db_out=0 or on reset. The rise pulse itself is not a repeat.
//  Undefined: no repeat logic; repeat_p tied to 0; the port list is unchanged.
// STRUCTURE
//  Shared package debounce_pkg holds:
//   - the clog2 helper for counter widths
//   - the default STABLE_TICKS, SYNC_STAGES, REPEAT_DELAY and REPEAT_RATE constants
//  Sub-module debounce_chan: one channel (sync, filter, edge pulses, optional repeat).
//   - Instantiated N_CH times in a generate loop.
//  Top level only adds the any_change reduction.
// TESTING
//  1. Defaults, tick=1, raw_in[0] 0->1 before edge 0 and held.
//     -> db_out[0]=1 after edge 4; rise[0]=1 for that one cycle only; any_change=1.
//  2. raw_in[1] high for 2 clk then low, tick=1.
//     -> db_out[1] stays 0; no rise/fall pulses.
//  3. tick every 4th clk, raw_in[2] 0->1.
//     -> db_out[2] flips on the 3rd tick edge after sync (edge SYNC_STAGES-1 plus 3 ticks).
//     -> held fixed on non-tick cycles.
//  4. raw_in[0] and raw_in[3] rise together; later both fall.
//     -> simultaneous rise pulses, then simultaneous fall pulses; any_change single cycle each time.
//  5. Channel stable high, reset for 1 clk with raw held.
//     -> db_out=0 next cycle with no fall pulse; returns to 1 exactly 5 edges after reset deasserts.
//  6. With DEBOUNCE_AUTOREPEAT_EN, REPEAT_DELAY=5, REPEAT_RATE=2, tick=1, held input.
//     -> repeat_p at 5, 7, 9 ticks after the flip; 0 after release.
//     -> without the macro, repeat_p stays 0.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and width helpers for the debounce bank.
package debounce_pkg;

  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_STABLE_TICKS = 3;
  localparam int DEF_REPEAT_DELAY = 50;
  localparam int DEF_REPEAT_RATE  = 10;

  // Bits needed to hold values 0..v-1, never less than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser, stable-count filter, edge pulses and
// optional auto-repeat (built only when DEBOUNCE_AUTOREPEAT_EN is defined).
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall,
  output logic repeat_p
);

  localparam int CW = clog2(STABLE_TICKS + 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounce_chan: SYNC_STAGES must be at least 2");
  end
  if (STABLE_TICKS < 1) begin : g_bad_stable
    $error("debounce_chan: STABLE_TICKS must be at least 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
    $error("debounce_chan: REPEAT_DELAY and REPEAT_RATE must be at least 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_nxt;
  logic                   s_out;
  logic                   flip;

  assign s_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_nxt = cnt;
    flip    = 1'b0;
    if (tick) begin
      if (s_out != db) begin
        if (cnt == CW'(STABLE_TICKS - 1)) begin
          flip    = 1'b1;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end else begin
        cnt_nxt = '0;
      end
    end
  end

  // Reset clears db without a fall pulse: pulses only come from filter flips.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      cnt    <= '0;
      db     <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      cnt    <= cnt_nxt;
      if (flip) db <= s_out;
      rise   <= flip & s_out;
      fall   <= flip & ~s_out;
    end
  end

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam int RW = clog2(max2(REPEAT_DELAY, REPEAT_RATE) + 1);

  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] rep_target;
  logic          rep_armed;

  // First pulse waits REPEAT_DELAY ticks, later ones REPEAT_RATE ticks.
  assign rep_target = rep_armed ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1);

  always_ff @(posedge clk) begin
    if (reset || !db) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
      repeat_p  <= 1'b0;
    end else begin
      repeat_p <= 1'b0;
      if (tick) begin
        if (rep_cnt == rep_target) begin
          repeat_p  <= 1'b1;
          rep_armed <= 1'b1;
          rep_cnt   <= '0;
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
        end
      end
    end
  end
`else
  assign repeat_p = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// N_CH independent debounce channels plus a combined change flag.
// Auto-repeat pulses exist only when DEBOUNCE_AUTOREPEAT_EN is defined.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] db_out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            any_change,
  output logic [N_CH-1:0] repeat_p
);

  for (genvar c = 0; c < N_CH; c++) begin : g_chan
    debounce_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_TICKS(STABLE_TICKS),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .raw     (raw_in[c]),
      .db      (db_out[c]),
      .rise    (rise[c]),
      .fall    (fall[c]),
      .repeat_p(repeat_p[c])
    );
  end

  assign any_change = |(rise | fall);

endmodule
